// File: rtl/op_fetch_pkg.sv
// op_fetch_pkg
// Shared definitions for the opcode fetch unit: the fetch FSM state type and
// the default address/data widths used by op_fetch and op_fetch_fifo.
package op_fetch_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/op_fetch_fifo.sv
// op_fetch_fifo
// Two-entry FIFO holding fetched {address, opcode} pairs.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   flush              synchronous clear of all entries (wins over push/pop)
//   push, push_data    write one entry
//   pop                remove the head entry
//   pop_data           head entry (valid while !empty)
//   full, empty        occupancy flags
import op_fetch_pkg::*;

module op_fetch_fifo #(
   parameter int W = ADDR_W_DEF + DATA_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;
   logic         push_ok;
   logic         pop_ok;

   assign full     = (cnt == 2'd2);
   assign empty    = (cnt == 2'd0);
   // A push into a full FIFO is accepted only when the head leaves this cycle.
   assign push_ok  = push & (~full | pop);
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   // Storage is cleared on reset so the head reads as zero until the first push.
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            mem[gi] <= '0;
         end else if (!flush && push_ok && (wr_ptr == 1'(gi))) begin
            mem[gi] <= push_data;
         end
      end
   end

endmodule

// File: rtl/op_fetch.sv
// op_fetch
// Opcode fetch unit: walks a synchronous opcode ROM from address 0 (or from a
// jump target) and delivers {address, opcode} pairs over a valid/ready port
// through a two-entry queue. Sustains one opcode per cycle while op_ready=1.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, halt, jump_en,
//   jump_addr                    control (priority jump_en > halt > start)
//   rom_ad, rom_ce, rom_oce,
//   rom_reset, rom_dout          ROM interface (data one cycle after rom_ce)
//   op_valid, op_ready,
//   op_data, op_addr             opcode output handshake
//   busy                         high whenever not IDLE
// Build option: define OP_FETCH_WRAP_EN to wrap from LAST_ADDR back to 0 and
// keep running; otherwise the unit drains and stops after LAST_ADDR.
import op_fetch_pkg::*;

module op_fetch #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int LAST_ADDR = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              halt,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] rom_ad,
   output logic              rom_ce,
   output logic              rom_oce,
   output logic              rom_reset,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_data,
   output logic [ADDR_W-1:0] op_addr,
   output logic              busy
);

   localparam int                QW     = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_next;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_addr;

   logic              issue;
   logic              pop;
   logic              push;
   logic              full;
   logic              empty;
   logic [QW-1:0]     head;
   logic [1:0]        q_level;
   logic [2:0]        outstanding;
   logic              room;

   // Reads in flight plus queued entries must never exceed the queue depth,
   // counting the slot freed by a pop in the same cycle.
   assign q_level     = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
   assign outstanding = {1'b0, q_level} + {2'b0, inflight};
   assign pop         = ~empty & op_ready;
   assign room        = (outstanding - {2'b0, pop}) < 3'd2;
   assign issue       = (state == RUN) & ~jump_en & ~halt & room;

   // A read in flight during a jump belongs to the old stream: drop it.
   assign push = inflight & ~jump_en;

   always_comb begin
      state_next = state;
      addr_next  = addr;
      if (jump_en) begin
         state_next = RUN;
         addr_next  = jump_addr;
      end else begin
         case (state)
            IDLE: begin
               if (!halt && start) begin
                  state_next = RUN;
                  addr_next  = '0;
               end
            end
            RUN: begin
               if (halt) begin
                  state_next = DRAIN;
               end else if (issue) begin
                  if (addr == LAST_A) begin
`ifdef OP_FETCH_WRAP_EN
                     addr_next = '0;
`else
                     state_next = DRAIN;
`endif
                  end else begin
                     addr_next = addr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!inflight && empty) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         addr          <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
      end else begin
         state    <= state_next;
         addr     <= addr_next;
         inflight <= issue;
         if (issue) inflight_addr <= addr;
      end
   end

   op_fetch_fifo #(
      .W (QW)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (jump_en),
      .push      (push),
      .push_data ({inflight_addr, rom_dout}),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   assign rom_ad    = addr;
   assign rom_ce    = issue;
   assign rom_oce   = 1'b1;
   assign rom_reset = 1'b0;
   assign op_valid  = ~empty;
   assign op_addr   = head[QW-1:DATA_W];
   assign op_data   = head[DATA_W-1:0];
   assign busy      = (state != IDLE);

endmodule

// File: doc/op_fetch.md
OP_FETCH -- requirements
Module: op_fetch

Interface
REQ-001 Parameter ADDR_W, default 3, ROM word-address width.
REQ-002 Parameter DATA_W, default 8, opcode width.
REQ-003 Parameter LAST_ADDR, default 7, final address of the opcode sequence.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin fetching at address 0; ignored unless IDLE.
REQ-007 halt  in  1  stop issuing reads and drain.
REQ-008 jump_en  in  1  flush and restart fetching at jump_addr.
REQ-009 jump_addr  in  ADDR_W  restart address.
REQ-010 rom_ad  out  ADDR_W  opcode ROM address.
REQ-011 rom_ce  out  1  ROM read enable; one read per high cycle.
REQ-012 rom_oce  out  1  ROM output enable; constant 1.
REQ-013 rom_reset  out  1  ROM synchronous output reset; constant 0.
REQ-014 rom_dout  in  DATA_W  ROM data, valid the cycle after its rom_ce cycle.
REQ-015 op_valid  out  1  op_data/op_addr hold a fetched opcode.
REQ-016 op_ready  in  1  consumer accepts; transfer when op_valid and op_ready are both high.
REQ-017 op_data  out  DATA_W  opcode at the queue head.
REQ-018 op_addr  out  ADDR_W  address the head opcode was read from.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN and DRAIN.
- IDLE->RUN on start, or on jump_en.
- RUN->DRAIN on halt, or after issuing LAST_ADDR (wrap disabled).
- DRAIN->IDLE once no read is in flight and the queue is empty.
REQ-021 Each issued read SHALL be pushed into a 2-entry queue with its address, the edge after its rom_ce cycle.
REQ-022 A read SHALL issue in RUN only when queue count + in-flight - (pop this cycle) < 2; back-to-back reads are allowed, so throughput is 1 opcode/cycle while op_ready=1.
REQ-023 Latency: start sampled at edge E0 -> rom_ce=1/rom_ad=0 in the following cycle -> op_valid=1 after E2.
REQ-024 rom_ad SHALL increment by 1 per issued read; the issue address after LAST_ADDR depends on the configuration (see Configuration).
REQ-025 op_data, op_addr and op_valid SHALL remain stable while op_valid=1 and op_ready=0.
REQ-026 On jump_en (any state), the fetch unit SHALL:
- empty the queue;
- discard any in-flight read (no push);
- enter RUN and issue jump_addr the next cycle.
REQ-027 Priority SHALL be jump_en > halt > start; a pop coinciding with jump_en completes, then the flush applies.
REQ-028 In DRAIN the fetch unit SHALL NOT assert rom_ce; queued opcodes are still delivered.
REQ-029 start while busy SHALL be ignored.

Reset
REQ-030 While reset_n=0 the fetch unit SHALL immediately:
- enter IDLE;
- drive rom_ce=0, rom_ad=0, op_valid=0, op_data=0, op_addr=0, busy=0;
- clear the queue and the in-flight flag.
REQ-031 Deassertion SHALL take effect at the first rising clk edge; reset mid-fetch drops all opcodes.

Configuration
REQ-032 Macro OP_FETCH_WRAP_EN:
- Defined: after LAST_ADDR the next read SHALL be address 0, and RUN continues until halt or jump_en.
- Undefined: after LAST_ADDR the FSM SHALL enter DRAIN.

Structure
REQ-033 Package op_fetch_pkg SHALL hold the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-034 The 2-entry queue SHALL be sub-module op_fetch_fifo, with push/pop, full/empty and synchronous flush.

Verification
REQ-035 ROM = 0x10..0x17, op_ready=1, start pulse -> 8 consecutive op_valid cycles with data 0x10..0x17 and addr 0..7; first valid 2 cycles after start; then IDLE (wrap undefined).
REQ-036 op_ready=0 after start -> exactly 2 reads issued, rom_ce=0 thereafter, op_data=0x10 stable; op_ready=1 -> remaining opcodes delivered in order, none lost or duplicated.
REQ-037 jump_en with jump_addr=5 mid-stream -> no stale opcode delivered; next opcode is 0x15 with addr 5.
REQ-038 halt at addr 3 -> no rom_ce after the halt cycle; in-flight and queued opcodes delivered; busy falls once the queue is empty.
REQ-039 OP_FETCH_WRAP_EN defined -> sequence 0x16, 0x17, 0x10 with addr 6, 7, 0; reset_n low mid-stream -> op_valid=0 immediately and state IDLE.
